// File: rtl/delay_cnt_sampler_if.sv
`timescale 1ns/1ps
// Data path bundle of the slow-to-fast word sampler: source word with its
// valid strobe, and the sampled word with its one-cycle valid pulse.
interface delay_cnt_sampler_if #(
  parameter int DW = 32
);
  logic [DW-1:0] din;
  logic          din_en;
  logic [DW-1:0] dout;
  logic          dout_en;

  modport master (output din, output din_en, input dout, input dout_en);
  modport slave  (input din, input din_en, output dout, output dout_en);
endinterface

// File: rtl/delay_cnt_sampler.sv
`timescale 1ns/1ps
// Slow-to-fast single-word CDC: a toggle flag is synchronised into clk2 and a
// fixed delay counter decides when the held source word is safe to sample.
module delay_cnt_sampler #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DELAY_CNT   = 3
) (
  input  logic               rstn,
  input  logic               clk1,
  input  logic               clk2,
  delay_cnt_sampler_if.slave bus
);
  localparam int               CNT_W    = $clog2(DELAY_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DW-1:0] hold_q, hold_d;
  logic          tog_q, tog_d;

  always_comb begin
    hold_d = hold_q;
    tog_d  = tog_q;
    if (bus.din_en) begin
      hold_d = bus.din;
      tog_d  = ~tog_q;
    end
  end

  // source domain (clk1)
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      hold_q <= '0;
      tog_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      tog_q  <= tog_d;
    end
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic                   tog_edge;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]          dout_q, dout_d;
  logic                   dout_en_q, dout_en_d;
  logic                   sample;

  // Any change of the synchronised flag, either polarity, announces one word.
  assign tog_edge = sync_q[SYNC_STAGES-1] ^ prev_q;
  // hold_q is read without a synchroniser: it has been static since the flag
  // flipped, which is at least SYNC_STAGES + DELAY_CNT clk2 cycles ago.
  assign sample   = (cnt_q == CNT_ONE) && !tog_edge;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], tog_q};
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    dout_en_d = 1'b0;
    if (tog_edge) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    if (sample) begin
      dout_d    = hold_q;
      dout_en_d = 1'b1;
    end
  end

  // destination domain (clk2)
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= sync_q[SYNC_STAGES-1];
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.dout_en = dout_en_q;
endmodule

// File: tb/tb_delay_cnt_sampler.sv
`timescale 1ns/1ps
// Bench for delay_cnt_sampler: default and (SYNC_STAGES=3, DELAY_CNT=1)
// instances fed the same slow stream, checked against a word-queue model.
module tb_delay_cnt_sampler;
  typedef struct {
    logic [31:0] d;
    int          t;
    int          s;
  } item_t;

  localparam int SS0 = 2, DC0 = 3;
  localparam int SS1 = 3, DC1 = 1;
  localparam int LMIN [2] = '{SS0 + DC0 + 1, SS1 + DC1 + 1};

  logic        clk_999khz = 1'b0;
  logic        clk2       = 1'b0;
  logic        rstn       = 1'b1;
  logic [31:0] din        = '0;
  logic        din_en     = 1'b0;

  int          n_chk   = 0;
  int          n_fail  = 0;
  int          c2_cnt  = 0;
  int          n_str   = 0;
  int          pulses0 = 0;
  int          p0      = 0;
  bit          stream_on = 1'b0;
  item_t       exp_q [2][$];
  logic [31:0] last_exp [2] = '{32'h0, 32'h0};
  logic        prev_en [2]  = '{1'b0, 1'b0};
  logic [31:0] dout_v [2];
  logic        en_v [2];

  delay_cnt_sampler_if #(.DW(32)) if0 ();
  delay_cnt_sampler_if #(.DW(32)) if1 ();

  assign if0.din    = din;
  assign if0.din_en = din_en;
  assign if1.din    = din;
  assign if1.din_en = din_en;
  assign dout_v[0]  = if0.dout;
  assign dout_v[1]  = if1.dout;
  assign en_v[0]    = if0.dout_en;
  assign en_v[1]    = if1.dout_en;

  delay_cnt_sampler #(.DW(32), .SYNC_STAGES(SS0), .DELAY_CNT(DC0)) dut0 (
    .rstn (rstn),
    .clk1 (clk_999khz),
    .clk2 (clk2),
    .bus  (if0)
  );

  delay_cnt_sampler #(.DW(32), .SYNC_STAGES(SS1), .DELAY_CNT(DC1)) dut1 (
    .rstn (rstn),
    .clk1 (clk_999khz),
    .clk2 (clk2),
    .bus  (if1)
  );

  always #500.5 clk_999khz = ~clk_999khz;
  always #5     clk2       = ~clk2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk2) c2_cnt++;

  // Model: every accepted source word must appear exactly once, in order.
  always @(posedge clk_999khz) begin
    item_t it;
    if (rstn && din_en) begin
      it.d = din;
      it.t = c2_cnt;
      it.s = stream_on ? n_str : -1;
      if (stream_on) n_str++;
      exp_q[0].push_back(it);
      exp_q[1].push_back(it);
    end
  end

  always @(negedge rstn) begin
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      last_exp[k] = '0;
    end
  end

  always @(negedge clk2) begin
    item_t it;
    int    lat;
    for (int k = 0; k < 2; k++) begin
      if (en_v[k]) begin
        if (k == 0) pulses0++;
        chk("pulse_width", 32'(prev_en[k]), 32'h0);
        if (exp_q[k].size() == 0) begin
          chk("spurious_dout_en", 32'(en_v[k]), 32'h0);
        end else begin
          it = exp_q[k].pop_front();
          chk("dout", dout_v[k], it.d);
          lat = c2_cnt - it.t;
          chk("latency_in_range", 32'(lat >= LMIN[k] && lat <= LMIN[k] + 1), 32'h1);
          if (it.s >= 0)
            chk("stream_seq", dout_v[k], 32'h5555AAAA + 32'h4321 * 32'(it.s + 1));
          last_exp[k] = it.d;
        end
      end else begin
        chk("dout_hold", dout_v[k], last_exp[k]);
      end
      prev_en[k] = en_v[k];
    end
  end

  initial begin
    din    = 32'h5555AAAA;
    din_en = 1'b0;
    #1 rstn = 1'b0;
    #6;
    chk("rst_dout0", if0.dout, 32'h0);
    chk("rst_en0", 32'(if0.dout_en), 32'h0);
    chk("rst_dout1", if1.dout, 32'h0);
    chk("rst_en1", 32'(if1.dout_en), 32'h0);
    #5 rstn = 1'b1;

    fork
      begin
        @(posedge clk_999khz);
        #1 p0 = pulses0;
        #10000;
        chk("pulses_10us", 32'(pulses0 - p0), 32'd9);
      end
    join_none

    stream_on = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_999khz);
      #1;
      din    = din + 32'h4321;
      din_en = 1'b1;
    end
    @(posedge clk_999khz);
    #1;
    stream_on = 1'b0;
    din_en    = 1'b0;

    for (int i = 0; i < 5; i++) begin
      din = $urandom;
      @(posedge clk_999khz);
      #1;
    end

    for (int i = 0; i < 10; i++) begin
      din    = $urandom;
      din_en = 1'($urandom_range(0, 1));
      @(posedge clk_999khz);
      #1;
    end

    din    = $urandom;
    din_en = 1'b1;
    @(posedge clk_999khz);
    #1 din_en = 1'b0;
    repeat (4) @(posedge clk2);
    #2 rstn = 1'b0;
    #10;
    chk("midrst_dout0", if0.dout, 32'h0);
    chk("midrst_en0", 32'(if0.dout_en), 32'h0);
    chk("midrst_dout1", if1.dout, 32'h0);
    chk("midrst_en1", 32'(if1.dout_en), 32'h0);
    #20 rstn = 1'b1;

    for (int i = 0; i < 3; i++) begin
      din    = $urandom;
      din_en = 1'b1;
      @(posedge clk_999khz);
      #1;
    end
    din_en = 1'b0;
    repeat (3) @(posedge clk_999khz);
    #1;
    chk("drain0", 32'(exp_q[0].size()), 32'h0);
    chk("drain1", 32'(exp_q[1].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
